// File: rtl/fpga_device.sv
// Board top: 3-digit BCD up/down counter on a scanned common-anode 7-segment display.
// Define FPGA_DEVICE_LZ_BLANK_EN to blank leading zeros on the tens and hundreds digits.
module fpga_device #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic [6:0] io_display,
    input  logic [1:0] sw,
    output logic [2:0] an
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

    logic [1:0]       sw_meta_q, sw_sync_q;
    logic [TickW-1:0] presc_q;
    logic [ScanW-1:0] scan_q;
    logic [1:0]       digit_idx_q;
    logic [3:0]       ones_q, tens_q, hund_q;
    logic [3:0]       ones_d, tens_d, hund_d;
    logic             tick, scan_wrap, run, down;

    assign run       = sw_sync_q[0];
    assign down      = sw_sync_q[1];
    assign tick      = (presc_q == TickLast);
    assign scan_wrap = (scan_q == ScanLast);

    // Returns {wrap, next}; out-of-range digits are pulled back to 0/9 without a carry.
    function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic dn);
        logic [4:0] r;
        if (!dn) begin
            if (d == 4'd9)     r = {1'b1, 4'd0};
            else if (d > 4'd9) r = {1'b0, 4'd0};
            else               r = {1'b0, d + 4'd1};
        end else begin
            if (d == 4'd0)     r = {1'b1, 4'd9};
            else if (d > 4'd9) r = {1'b0, 4'd9};
            else               r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    always_comb begin
        logic [4:0] o_step, t_step, h_step;
        o_step = bcd_step(ones_q, down);
        t_step = bcd_step(tens_q, down);
        h_step = bcd_step(hund_q, down);
        ones_d = ones_q;
        tens_d = tens_q;
        hund_d = hund_q;
        if (tick && run) begin
            ones_d = o_step[3:0];
            if (o_step[4]) begin
                tens_d = t_step[3:0];
                if (t_step[4]) hund_d = h_step[3:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_q   <= 2'b00;
            sw_sync_q   <= 2'b00;
            presc_q     <= '0;
            scan_q      <= '0;
            digit_idx_q <= 2'd0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            hund_q      <= 4'd0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            presc_q   <= tick ? '0 : presc_q + TickW'(1);
            scan_q    <= scan_wrap ? '0 : scan_q + ScanW'(1);
            if (scan_wrap) digit_idx_q <= (digit_idx_q >= 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
            ones_q <= ones_d;
            tens_q <= tens_d;
            hund_q <= hund_d;
        end
    end

    always_comb begin
        logic [3:0] digit;
        logic       blank;
        an    = 3'b111;
        digit = 4'hF;
        blank = 1'b0;
        case (digit_idx_q)
            2'd0: begin
                an    = 3'b110;
                digit = ones_q;
            end
            2'd1: begin
                an    = 3'b101;
                digit = tens_q;
`ifdef FPGA_DEVICE_LZ_BLANK_EN
                blank = (hund_q == 4'd0) && (tens_q == 4'd0);
`endif
            end
            2'd2: begin
                an    = 3'b011;
                digit = hund_q;
`ifdef FPGA_DEVICE_LZ_BLANK_EN
                blank = (hund_q == 4'd0);
`endif
            end
            default: begin
                an    = 3'b111;
                digit = 4'hF;
            end
        endcase
        io_display = blank ? 7'b1111111 : glyph(digit);
    end

endmodule

// File: tb/tb_fpga_device.sv
// Randomized bench for fpga_device: an integer-count model with a 2-edge switch delay is
// compared against the display and anodes after every clock edge.
module tb_fpga_device;

    localparam int TD = 4;
    localparam int SD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] sw;
    logic [6:0] io_display;
    logic [2:0] an;

    fpga_device #(
        .TICK_DIV(TD),
        .SCAN_DIV(SD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_display(io_display),
        .sw(sw),
        .an(an)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    // Model: edges since reset release, decimal count, switch values seen 1 and 2 edges back.
    int         e;
    int         count;
    logic [1:0] sw_m1, sw_m2;

    function automatic int glyph_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, count %0d)",
                      name, act, exp, e, count);
    endtask

    task automatic model_reset();
        e     = 0;
        count = 0;
        sw_m1 = 2'b00;
        sw_m2 = 2'b00;
    endtask

    task automatic model_edge();
        e++;
        if (((e - 1) % TD) == TD - 1 && sw_m2[0])
            count = sw_m2[1] ? (count + 999) % 1000 : (count + 1) % 1000;
        sw_m2 = sw_m1;
        sw_m1 = sw;
    endtask

    task automatic compare_outputs();
        int idx, d, exp_disp;
        bit blank;
        idx   = (e / SD) % 3;
        blank = 1'b0;
        case (idx)
            0: d = count % 10;
            1: d = (count / 10) % 10;
            default: d = count / 100;
        endcase
`ifdef FPGA_DEVICE_LZ_BLANK_EN
        if (idx == 2 && count < 100) blank = 1'b1;
        if (idx == 1 && count < 10) blank = 1'b1;
`endif
        exp_disp = blank ? 7'b1111111 : glyph_of(d);
        check("an", int'(an), int'(~(3'b001 << idx) & 3'b111));
        check("io_display", int'(io_display), exp_disp);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_outputs();
    endtask

    initial begin
        int lz_blank7;
`ifdef FPGA_DEVICE_LZ_BLANK_EN
        lz_blank7 = 7'b1111111;
`else
        lz_blank7 = 7'b1000000;
`endif
        reset = 1'b1;
        sw    = 2'b01;
        model_reset();
        repeat (2) begin
            @(negedge clock);
            check("reset_an", int'(an), 3'b110);
            check("reset_disp", int'(io_display), 7'b1000000);
        end
        reset = 1'b0;

        // Count up from 000 with run held high.
        repeat (50) begin
            cycle();
            if (e == 28) begin
                check("model_count_7", count, 7);
                check("cnt7_an", int'(an), 3'b011);
                check("cnt7_hund_disp", int'(io_display), lz_blank7);
            end
            if (e == 42) begin
                check("model_count_10", count, 10);
                check("cnt10_an", int'(an), 3'b110);
                check("cnt10_ones_disp", int'(io_display), 7'b1000000);
            end
            if (e == 44) begin
                check("cnt11_an", int'(an), 3'b101);
                check("cnt11_tens_disp", int'(io_display), 7'b1111001);
            end
        end

        // Random switch activity.
        repeat (600) begin
            cycle();
            if ($urandom_range(0, 15) == 0) sw = 2'($urandom_range(0, 3));
        end

        // Asynchronous reset mid-count.
        sw = 2'b01;
        repeat (20) cycle();
        #2 reset = 1'b1;
        #1;
        check("async_reset_an", int'(an), 3'b110);
        check("async_reset_disp", int'(io_display), 7'b1000000);
        model_reset();
        sw = 2'b11;
        @(negedge clock);
        reset = 1'b0;

        // Down from 000 wraps to 999, then up from 999 wraps to 000.
        repeat (4) cycle();
        check("model_count_999", count, 999);
        check("cnt999_an", int'(an), 3'b011);
        check("cnt999_disp", int'(io_display), 7'b0010000);
        sw = 2'b01;
        repeat (4) cycle();
        check("model_wrap_000", count, 0);
        repeat (200) begin
            cycle();
            if ($urandom_range(0, 31) == 0) sw = 2'($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
